// File: rtl/gmii_byte_pack.sv
// gmii_byte_pack: packs the 9-bit GMII receive byte stream into 134-bit words.
// Optional statistics counters are enabled by defining GMII_BYTE_PACK_STAT_EN.
//
// Ports:
//   clk_sys, reset    system clock, asynchronous active-high reset
//   iv_data[8:0]      byte stream; [8] marks head/tail, [7:0] byte
//   i_data_wr         iv_data valid
//   iv_rec_ts[18:0]   receive timestamp, valid with the head byte
//   ov_data[133:0]    {type[1:0], invalid count[3:0], data[127:0]}
//   o_data_wr         ov_data valid strobe
//   ov_rec_ts[18:0]   head timestamp on head-type words, else 0
//   ov_pkt_len[11:0]  forwarded byte count on tail-type words, else 0
//   o_trunc_pulse     frame was cut at MAX_LEN
//   o_stray_pulse     byte dropped outside a frame
//   ov_pkt_cnt, ov_trunc_cnt, ov_stray_cnt  (GMII_BYTE_PACK_STAT_EN only)
module gmii_byte_pack #(
    parameter int MAX_LEN = 2048
) (
    input  logic         clk_sys,
    input  logic         reset,
    input  logic [8:0]   iv_data,
    input  logic         i_data_wr,
    input  logic [18:0]  iv_rec_ts,
    output logic [133:0] ov_data,
    output logic         o_data_wr,
    output logic [18:0]  ov_rec_ts,
    output logic [11:0]  ov_pkt_len,
    output logic         o_trunc_pulse,
    output logic         o_stray_pulse
`ifdef GMII_BYTE_PACK_STAT_EN
    ,
    output logic [15:0]  ov_pkt_cnt,
    output logic [15:0]  ov_trunc_cnt,
    output logic [15:0]  ov_stray_cnt
`endif
);

    localparam logic [11:0] LP_MAX = 12'(MAX_LEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PACK,
        S_DISCARD
    } state_t;

    state_t         r_state;
    logic [3:0]     r_lane;
    logic [11:0]    r_len;
    logic [127:0]   r_stage;
    logic           r_first;
    logic [18:0]    r_ts;

    logic           w_tail;
    logic [11:0]    w_len_nxt;
    logic           w_at_max;
    logic [3:0]     w_inv;
    logic [127:0]   w_word;

    assign w_tail    = iv_data[8];
    assign w_len_nxt = r_len + 12'd1;
    assign w_at_max  = (w_len_nxt == LP_MAX);
    // Lanes above r_lane are still zero, so OR-ing the new byte in is safe.
    assign w_word    = r_stage
                     | ({iv_data[7:0], 120'd0} >> {r_lane, 3'b000});
    // Filled lanes = r_lane + 1, so 16 - filled = 15 - r_lane.
    assign w_inv     = 4'd15 - r_lane;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_lane        <= 4'd0;
            r_len         <= 12'd0;
            r_stage       <= 128'd0;
            r_first       <= 1'b0;
            r_ts          <= 19'd0;
            ov_data       <= 134'd0;
            o_data_wr     <= 1'b0;
            ov_rec_ts     <= 19'd0;
            ov_pkt_len    <= 12'd0;
            o_trunc_pulse <= 1'b0;
            o_stray_pulse <= 1'b0;
        end else begin
            ov_data       <= 134'd0;
            o_data_wr     <= 1'b0;
            ov_rec_ts     <= 19'd0;
            ov_pkt_len    <= 12'd0;
            o_trunc_pulse <= 1'b0;
            o_stray_pulse <= 1'b0;
            if (i_data_wr) begin
                unique case (r_state)
                    S_IDLE: begin
                        if (w_tail) begin
                            r_stage <= {iv_data[7:0], 120'd0};
                            r_lane  <= 4'd1;
                            r_len   <= 12'd1;
                            r_first <= 1'b1;
                            r_ts    <= iv_rec_ts;
                            r_state <= S_PACK;
                        end else begin
                            o_stray_pulse <= 1'b1;
                        end
                    end
                    S_PACK: begin
                        r_len <= w_len_nxt;
                        // A real tail wins over truncation when both
                        // land on the same byte.
                        if (w_tail || w_at_max) begin
                            o_data_wr     <= 1'b1;
                            ov_data       <= {1'b1, r_first, w_inv, w_word};
                            ov_rec_ts     <= r_first ? r_ts : 19'd0;
                            ov_pkt_len    <= w_len_nxt;
                            o_trunc_pulse <= ~w_tail;
                            r_stage       <= 128'd0;
                            r_lane        <= 4'd0;
                            r_first       <= 1'b0;
                            r_state       <= w_tail ? S_IDLE : S_DISCARD;
                        end else if (r_lane == 4'd15) begin
                            o_data_wr <= 1'b1;
                            ov_data   <= {1'b0, r_first, 4'd0, w_word};
                            ov_rec_ts <= r_first ? r_ts : 19'd0;
                            r_stage   <= 128'd0;
                            r_lane    <= 4'd0;
                            r_first   <= 1'b0;
                        end else begin
                            r_stage <= w_word;
                            r_lane  <= r_lane + 4'd1;
                        end
                    end
                    S_DISCARD: begin
                        if (w_tail) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef GMII_BYTE_PACK_STAT_EN
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ov_pkt_cnt   <= 16'd0;
            ov_trunc_cnt <= 16'd0;
            ov_stray_cnt <= 16'd0;
        end else begin
            if (o_data_wr && ov_data[133]) begin
                ov_pkt_cnt <= ov_pkt_cnt + 16'd1;
            end
            if (o_trunc_pulse) begin
                ov_trunc_cnt <= ov_trunc_cnt + 16'd1;
            end
            if (o_stray_pulse) begin
                ov_stray_cnt <= ov_stray_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_gmii_byte_pack.sv
// tb_gmii_byte_pack: two instances (MAX_LEN 2048 and 32) share one stimulus;
// a frame-level model predicts every emitted word.
module tb_gmii_byte_pack;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    logic         reset;
    logic [8:0]   iv_data;
    logic         i_data_wr;
    logic [18:0]  iv_rec_ts;

    logic [133:0] a_data, b_data;
    logic         a_wr, b_wr;
    logic [18:0]  a_ts, b_ts;
    logic [11:0]  a_len, b_len;
    logic         a_tr, b_tr, a_st, b_st;
`ifdef GMII_BYTE_PACK_STAT_EN
    logic [15:0]  a_pc, a_tc, a_sc, b_pc, b_tc, b_sc;
`endif

    gmii_byte_pack #(.MAX_LEN(2048)) dut_a (
        .clk_sys(clk_sys), .reset(reset), .iv_data(iv_data),
        .i_data_wr(i_data_wr), .iv_rec_ts(iv_rec_ts),
        .ov_data(a_data), .o_data_wr(a_wr), .ov_rec_ts(a_ts),
        .ov_pkt_len(a_len), .o_trunc_pulse(a_tr), .o_stray_pulse(a_st)
`ifdef GMII_BYTE_PACK_STAT_EN
        , .ov_pkt_cnt(a_pc), .ov_trunc_cnt(a_tc), .ov_stray_cnt(a_sc)
`endif
    );

    gmii_byte_pack #(.MAX_LEN(32)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .iv_data(iv_data),
        .i_data_wr(i_data_wr), .iv_rec_ts(iv_rec_ts),
        .ov_data(b_data), .o_data_wr(b_wr), .ov_rec_ts(b_ts),
        .ov_pkt_len(b_len), .o_trunc_pulse(b_tr), .o_stray_pulse(b_st)
`ifdef GMII_BYTE_PACK_STAT_EN
        , .ov_pkt_cnt(b_pc), .ov_trunc_cnt(b_tc), .ov_stray_cnt(b_sc)
`endif
    );

    typedef struct {
        logic [133:0] data;
        logic [18:0]  ts;
        logic [11:0]  plen;
    } exp_t;

    typedef struct {
        int          n;
        logic [7:0]  seed;
        bit          bub;
        logic [18:0] ts;
        int          nwa;
        logic [3:0]  ia;
        int          la;
        int          nwb;
        logic [3:0]  ib;
        int          lb;
        int          trb;
    } vec_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;
    int checks = 0;
    int failures = 0;
    logic [7:0] fb [0:4095];

    int wa, wb, tra, trb, sta, stb;
    logic [1:0]  lta, ltb;
    logic [3:0]  lia, lib;
    logic [11:0] lla, llb;

    task automatic chk_i(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic chk_v(input string nm, input logic [191:0] got,
                         input logic [191:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, got, want);
        end
    endtask

    // Scoreboard: every strobed word must match the next predicted word.
    always @(negedge clk_sys) begin
        if (a_wr) begin
            wa++;
            lta = a_data[133:132];
            lia = a_data[131:128];
            lla = a_len;
            checks++;
            if (qa.size() == 0) begin
                failures++;
                $display("FAIL word_a unexpected got=%h", a_data);
            end else begin
                ea = qa.pop_front();
                if (a_data !== ea.data || a_ts !== ea.ts
                    || a_len !== ea.plen) begin
                    failures++;
                    $display("FAIL word_a got=%h/%h/%0d want=%h/%h/%0d",
                             a_data, a_ts, a_len, ea.data, ea.ts, ea.plen);
                end
            end
        end
        if (b_wr) begin
            wb++;
            ltb = b_data[133:132];
            lib = b_data[131:128];
            llb = b_len;
            checks++;
            if (qb.size() == 0) begin
                failures++;
                $display("FAIL word_b unexpected got=%h", b_data);
            end else begin
                eb = qb.pop_front();
                if (b_data !== eb.data || b_ts !== eb.ts
                    || b_len !== eb.plen) begin
                    failures++;
                    $display("FAIL word_b got=%h/%h/%0d want=%h/%h/%0d",
                             b_data, b_ts, b_len, eb.data, eb.ts, eb.plen);
                end
            end
        end
        if (a_tr) tra++;
        if (b_tr) trb++;
        if (a_st) sta++;
        if (b_st) stb++;
    end

    task automatic clear_mon();
        wa = 0; wb = 0; tra = 0; trb = 0; sta = 0; stb = 0;
        lta = 2'd0; ltb = 2'd0; lia = 4'd0; lib = 4'd0;
        lla = 12'd0; llb = 12'd0;
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic fill(input int n, input logic [7:0] seed, input bit rnd);
        for (int i = 0; i < n; i++) begin
            fb[i] = rnd ? 8'($urandom) : 8'(int'(seed) + i);
        end
    endtask

    // Frame-level model: forward min(n, max) bytes in 16-byte words.
    task automatic model(input int which, input int n_in,
                         input logic [18:0] ts);
        int maxl, n, nw, idx;
        exp_t e;
        logic [127:0] d;
        logic first, last;
        maxl = (which == 0) ? 2048 : 32;
        n = (n_in > maxl) ? maxl : n_in;
        nw = (n + 15) / 16;
        for (int w = 0; w < nw; w++) begin
            d = 128'd0;
            for (int k = 0; k < 16; k++) begin
                idx = 16 * w + k;
                if (idx < n) d[127 - 8 * k -: 8] = fb[idx];
            end
            first = (w == 0);
            last = (w == nw - 1);
            e.data = {last, first, last ? 4'(16 * nw - n) : 4'd0, d};
            e.ts = first ? ts : 19'd0;
            e.plen = last ? 12'(n) : 12'd0;
            if (which == 0) qa.push_back(e);
            else qb.push_back(e);
        end
    endtask

    task automatic send_byte(input logic hd, input logic [7:0] b,
                             input logic [18:0] ts, input bit bub);
        if (bub) wait_cyc($urandom_range(0, 3));
        i_data_wr = 1'b1;
        iv_data = {hd, b};
        iv_rec_ts = ts;
        @(posedge clk_sys);
        #1;
        i_data_wr = 1'b0;
        iv_data = 9'($urandom);
        iv_rec_ts = 19'($urandom);
    endtask

    task automatic send_frame(input int n, input logic [18:0] ts,
                              input bit bub);
        for (int i = 0; i < n; i++) begin
            send_byte((i == 0) || (i == n - 1), fb[i],
                      (i == 0) ? ts : 19'($urandom), bub);
        end
    endtask

    vec_t tbl [10];

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int ns, n, exp_st, exp_tr;
        logic [18:0] ts;

        tbl[0] = '{64, 8'h00, 1'b0, 19'h12345, 4, 4'd0, 64, 2, 4'd0, 32, 1};
        tbl[1] = '{60, 8'h40, 1'b1, 19'h00abc, 4, 4'd4, 60, 2, 4'd0, 32, 1};
        tbl[2] = '{10, 8'h80, 1'b0, 19'h7ffff, 1, 4'd6, 10, 1, 4'd6, 10, 0};
        tbl[3] = '{100, 8'h10, 1'b0, 19'h00001, 7, 4'd12, 100,
                   2, 4'd0, 32, 1};
        tbl[4] = '{20, 8'h20, 1'b1, 19'h00002, 2, 4'd12, 20,
                   2, 4'd12, 20, 0};
        tbl[5] = '{16, 8'h30, 1'b0, 19'h00003, 1, 4'd0, 16, 1, 4'd0, 16, 0};
        tbl[6] = '{17, 8'h31, 1'b1, 19'h00004, 2, 4'd15, 17,
                   2, 4'd15, 17, 0};
        tbl[7] = '{32, 8'h32, 1'b0, 19'h00005, 2, 4'd0, 32, 2, 4'd0, 32, 0};
        tbl[8] = '{33, 8'h33, 1'b0, 19'h00006, 3, 4'd15, 33,
                   2, 4'd0, 32, 1};
        tbl[9] = '{2, 8'hff, 1'b0, 19'h00007, 1, 4'd14, 2, 1, 4'd14, 2, 0};

        reset = 1'b1;
        i_data_wr = 1'b0;
        iv_data = 9'd0;
        iv_rec_ts = 19'd0;
        clear_mon();
        wait_cyc(3);
        chk_v("reset_out_a", 192'({a_wr, a_data, a_ts, a_len, a_tr, a_st}),
              192'd0);
        chk_v("reset_out_b", 192'({b_wr, b_data, b_ts, b_len, b_tr, b_st}),
              192'd0);
        reset = 1'b0;
        wait_cyc(2);

        for (int i = 0; i < 10; i++) begin
            clear_mon();
            fill(tbl[i].n, tbl[i].seed, 1'b0);
            model(0, tbl[i].n, tbl[i].ts);
            model(1, tbl[i].n, tbl[i].ts);
            send_frame(tbl[i].n, tbl[i].ts, tbl[i].bub);
            wait_cyc(4);
            chk_i($sformatf("nwords_a[%0d]", i), wa, tbl[i].nwa);
            chk_v($sformatf("last_a[%0d]", i), 192'({lta, lia, lla}),
                  192'({(tbl[i].nwa == 1) ? 2'b11 : 2'b10, tbl[i].ia,
                        12'(tbl[i].la)}));
            chk_i($sformatf("trunc_a[%0d]", i), tra, 0);
            chk_i($sformatf("nwords_b[%0d]", i), wb, tbl[i].nwb);
            chk_v($sformatf("last_b[%0d]", i), 192'({ltb, lib, llb}),
                  192'({(tbl[i].nwb == 1) ? 2'b11 : 2'b10, tbl[i].ib,
                        12'(tbl[i].lb)}));
            chk_i($sformatf("trunc_b[%0d]", i), trb, tbl[i].trb);
            chk_i($sformatf("stray_b[%0d]", i), stb, 0);
            chk_i($sformatf("drain[%0d]", i), qa.size() + qb.size(), 0);
        end

        // Stray bytes in IDLE, then an exactly-full single-word frame.
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            send_byte(1'b0, 8'($urandom), 19'($urandom), 1'b0);
        end
        fill(16, 8'h70, 1'b0);
        model(0, 16, 19'h0abcd);
        model(1, 16, 19'h0abcd);
        send_frame(16, 19'h0abcd, 1'b0);
        wait_cyc(4);
        chk_i("stray_seq_a", sta, 3);
        chk_i("stray_seq_b", stb, 3);
        chk_i("stray_nw_a", wa, 1);
        chk_v("stray_last_a", 192'({lta, lia, lla}),
              192'({2'b11, 4'd0, 12'd16}));

        // Reset after byte 20 of a 64-byte frame.
        clear_mon();
        fill(64, 8'h55, 1'b0);
        model(0, 64, 19'h11111);
        model(1, 64, 19'h11111);
        for (int i = 0; i < 20; i++) begin
            send_byte(i == 0, fb[i], (i == 0) ? 19'h11111 : 19'($urandom),
                      1'b0);
        end
        reset = 1'b1;
        #1;
        chk_v("midrst_out_a",
              192'({a_wr, a_data, a_ts, a_len, a_tr, a_st}), 192'd0);
        chk_v("midrst_out_b",
              192'({b_wr, b_data, b_ts, b_len, b_tr, b_st}), 192'd0);
        chk_i("midrst_words_a", wa, 1);
        chk_i("midrst_left_a", qa.size(), 3);
        chk_i("midrst_left_b", qb.size(), 1);
        qa.delete();
        qb.delete();
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(3);
        clear_mon();
        fill(20, 8'h99, 1'b0);
        model(0, 20, 19'h22222);
        model(1, 20, 19'h22222);
        send_frame(20, 19'h22222, 1'b0);
        wait_cyc(4);
        chk_i("postrst_nw_a", wa, 2);
        chk_v("postrst_last_a", 192'({lta, lia, lla}),
              192'({2'b10, 4'd12, 12'd20}));
        chk_i("postrst_drain", qa.size() + qb.size(), 0);
`ifdef GMII_BYTE_PACK_STAT_EN
        chk_i("pkt_cnt_a", int'(a_pc), 1);
        chk_i("pkt_cnt_b", int'(b_pc), 1);
        chk_i("stray_cnt_a", int'(a_sc), 0);
`endif

        // Randomized frames with strays, bubbles and back-to-back heads.
        clear_mon();
        exp_st = 0;
        exp_tr = 0;
        for (int it = 0; it < 40; it++) begin
            ns = $urandom_range(0, 2);
            for (int s = 0; s < ns; s++) begin
                send_byte(1'b0, 8'($urandom), 19'($urandom), 1'b1);
            end
            exp_st += ns;
            n = $urandom_range(2, 120);
            ts = 19'($urandom);
            fill(n, 8'd0, 1'b1);
            model(0, n, ts);
            model(1, n, ts);
            send_frame(n, ts, $urandom_range(0, 1) == 1);
            if (n > 32) exp_tr++;
        end
        wait_cyc(4);
        chk_i("rand_stray_a", sta, exp_st);
        chk_i("rand_stray_b", stb, exp_st);
        chk_i("rand_trunc_a", tra, 0);
        chk_i("rand_trunc_b", trb, exp_tr);
        chk_i("rand_drain", qa.size() + qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
